if_id_skid: RTL and testbench

- IF/ID pipeline boundary register: captures the fetched address/instruction pair from the fetch stage and presents it, registered, to the decode stage.
- Two-entry skid buffer (main + skid) so a decode stall never drops a fetched instruction, even though the fetch-side ready is registered.
- Flush input (branch/jump redirect from execute) squashes all buffered entries; decode sees a NOP bubble while the buffer is empty.

---
 rtl/pipe_pkg.sv | 30 +++
 rtl/sat_counter8.sv | 40 ++++
 rtl/if_id_skid.sv | 137 +++++++++++++
 tb/tb_if_id_skid.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipe_pkg
// Description : Types and default constants shared by the pipeline boundary
//               registers (IF/ID now, ID/EX later).
//               - NOP_INST_DEF / RESET_ADDR_DEF : parameter defaults
//               - skid_state_e                  : two-entry buffer occupancy
//               - fetch_pkt_t                   : address/instruction pair
// Revision    : 1.0 - initial release
// ============================================================================
package pipe_pkg;

  // RV32I "addi x0, x0, 0", the canonical bubble.
  localparam logic [31:0] NOP_INST_DEF   = 32'h0000_0013;
  localparam logic [31:0] RESET_ADDR_DEF = 32'h0000_0000;

  // Occupancy of a main + skid pair of entries.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,  // main invalid, skid invalid
    ONE   = 2'd1,  // main valid,   skid invalid
    TWO   = 2'd2   // main valid,   skid valid
  } skid_state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } fetch_pkt_t;

endpackage
`default_nettype wire

// File: rtl/sat_counter8.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter8
// Description : 8-bit accumulator that saturates at 8'hFF and never wraps.
//               Synchronous active-low clear.
//   clk   in   clock
//   rst   in   synchronous active-low clear
//   inc   in   8-bit increment applied every cycle
//   count out  registered saturating total
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter8 (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] inc,
  output logic [7:0] count
);

  logic [7:0] count_q;
  logic [7:0] count_d;
  logic [8:0] sum;

  // A ninth bit catches the carry so overflow clamps instead of wrapping.
  always_comb begin
    sum     = {1'b0, count_q} + {1'b0, inc};
    count_d = sum[8] ? 8'hFF : sum[7:0];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q <= 8'h00;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/if_id_skid.sv
`default_nettype none
// ============================================================================
// Module      : if_id_skid
// Description : IF/ID pipeline register with a two-entry (main + skid)
//               buffer so a registered fetch-side ready never loses an
//               instruction when decode stalls. Flush squashes both entries.
//   clk         in   rising-edge clock
//   rst         in   synchronous active-low reset
//   if_addr     in   fetched PC
//   if_inst     in   fetched instruction
//   if_valid    in   fetch data valid (transfer = if_valid & if_ready)
//   if_ready    out  buffer can accept (registered)
//   id_addr     out  PC to decode
//   id_inst     out  instruction to decode (NOP while empty)
//   id_valid    out  decode data valid
//   id_stall    in   decode cannot consume (consume = id_valid & ~id_stall)
//   flush       in   squash all buffered entries
//   flush_drops out  saturating count of entries discarded by flush
// Revision    : 1.0 - initial release
// ============================================================================
module if_id_skid
  import pipe_pkg::*;
#(
  parameter logic [31:0] NOP_INST   = NOP_INST_DEF,
  parameter logic [31:0] RESET_ADDR = RESET_ADDR_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_addr,
  input  logic [31:0] if_inst,
  input  logic        if_valid,
  output logic        if_ready,
  output logic [31:0] id_addr,
  output logic [31:0] id_inst,
  output logic        id_valid,
  input  logic        id_stall,
  input  logic        flush,
  output logic [7:0]  flush_drops
);

  skid_state_e state_q, state_d;
  fetch_pkt_t  main_q, main_d;
  fetch_pkt_t  skid_q, skid_d;
  logic        id_valid_q, id_valid_d;
  logic        if_ready_q, if_ready_d;

  fetch_pkt_t  in_pkt;
  logic        transfer;
  logic        consume;
  logic        main_dropped;
  logic        skid_dropped;
  logic [7:0]  drop_inc;

  always_comb begin
    in_pkt       = '{addr: if_addr, inst: if_inst};
    transfer     = if_valid & if_ready_q;
    consume      = id_valid_q & ~id_stall;
    // A main entry consumed in the flush cycle reached decode, so it is not a drop.
    main_dropped = (state_q != EMPTY) & ~consume;
    skid_dropped = (state_q == TWO);

    state_d  = state_q;
    main_d   = main_q;
    skid_d   = skid_q;
    drop_inc = 8'h00;

    if (flush) begin
      state_d  = EMPTY;
      drop_inc = {7'd0, main_dropped} + {7'd0, skid_dropped} + {7'd0, transfer};
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (transfer) begin
            main_d  = in_pkt;
            state_d = ONE;
          end
        end
        ONE: begin
          if (consume && transfer) begin
            main_d = in_pkt;
          end else if (consume) begin
            state_d = EMPTY;
          end else if (transfer) begin
            skid_d  = in_pkt;
            state_d = TWO;
          end
        end
        TWO: begin
          // if_ready is low here, so no new entry can arrive this cycle.
          if (consume) begin
            main_d  = skid_q;
            state_d = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    // Empty buffer shows a bubble; the stale address is deliberately kept.
    if (state_d == EMPTY) begin
      main_d.inst = NOP_INST;
    end

    id_valid_d = (state_d != EMPTY);
    if_ready_d = (state_d != TWO);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= EMPTY;
      main_q     <= '{addr: RESET_ADDR, inst: NOP_INST};
      skid_q     <= '0;
      id_valid_q <= 1'b0;
      if_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      id_valid_q <= id_valid_d;
      if_ready_q <= if_ready_d;
    end
  end

  sat_counter8 u_drop_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (drop_inc),
    .count (flush_drops)
  );

  assign id_addr  = main_q.addr;
  assign id_inst  = main_q.inst;
  assign id_valid = id_valid_q;
  assign if_ready = if_ready_q;

endmodule
`default_nettype wire

// File: tb/tb_if_id_skid.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_id_skid
// Description : Self-checking bench for if_id_skid. A queue-based model of
//               the two-entry buffer predicts every output each cycle;
//               directed literal checks pin the model at key points.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_id_skid;
  import pipe_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic [31:0] if_inst = 32'h0;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [31:0] id_addr;
  logic [31:0] id_inst;
  logic        id_valid;
  logic        id_stall = 1'b0;
  logic        flush = 1'b0;
  logic [7:0]  flush_drops;

  if_id_skid dut (
    .clk         (clk),
    .rst         (rst),
    .if_addr     (if_addr),
    .if_inst     (if_inst),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .id_addr     (id_addr),
    .id_inst     (id_inst),
    .id_valid    (id_valid),
    .id_stall    (id_stall),
    .flush       (flush),
    .flush_drops (flush_drops)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Model: FIFO of at most two packets, plus drop count and last shown address.
  fetch_pkt_t  mq[$];
  int          m_drops = 0;
  logic [31:0] m_last_addr = 32'h0;
  bit          cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] a);
    if_valid = v;
    if_addr  = a;
    if_inst  = 32'hA500_0000 ^ a;
  endtask

  // One clock: update the model with the inputs the DUT sees at this edge.
  task automatic tick();
    int tr;
    int cs;
    fetch_pkt_t p;
    @(posedge clk);
    tr = (if_valid && mq.size() < 2) ? 1 : 0;
    cs = (mq.size() > 0 && !id_stall) ? 1 : 0;
    p.addr = if_addr;
    p.inst = if_inst;
    if (!rst) begin
      mq.delete();
      m_drops     = 0;
      m_last_addr = 32'h0;
    end else if (flush) begin
      m_drops = m_drops + mq.size() - cs + tr;
      if (m_drops > 255) m_drops = 255;
      mq.delete();
    end else begin
      if (cs != 0) void'(mq.pop_front());
      if (tr != 0) mq.push_back(p);
    end
    if (mq.size() > 0) m_last_addr = mq[0].addr;
    cmp_en = 1'b1;
    #1;
  endtask

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("id_valid", {31'd0, id_valid}, {31'd0, mq.size() > 0});
      chk("id_addr", id_addr, (mq.size() > 0) ? mq[0].addr : m_last_addr);
      chk("id_inst", id_inst, (mq.size() > 0) ? mq[0].inst : NOP);
      chk("if_ready", {31'd0, if_ready}, {31'd0, mq.size() < 2});
      chk("flush_drops", {24'd0, flush_drops}, m_drops);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with if_valid and flush active: reset must win.
    rst = 1'b0; flush = 1'b1; drive(1'b1, 32'h50);
    tick(); tick();
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_id_inst", id_inst, 32'h0000_0013);
    chk("rst_id_addr", id_addr, 32'h0);
    chk("rst_if_ready", {31'd0, if_ready}, 32'd1);
    chk("rst_drops", {24'd0, flush_drops}, 32'd0);

    // Streaming with no stall: one per cycle, one-cycle latency.
    rst = 1'b1; flush = 1'b0; id_stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 32'(i * 4));
      tick();
      chk("stream_addr", id_addr, 32'(i * 4));
      chk("stream_ready", {31'd0, if_ready}, 32'd1);
    end
    drive(1'b0, 32'h0);
    tick();
    chk("stream_drain_valid", {31'd0, id_valid}, 32'd0);

    // Stall fill to TWO, then release.
    drive(1'b1, 32'h10); tick();
    id_stall = 1'b1; drive(1'b1, 32'h14); tick();
    drive(1'b1, 32'h18); tick();
    chk("fill_ready", {31'd0, if_ready}, 32'd0);
    chk("fill_head", id_addr, 32'h10);
    id_stall = 1'b0; tick();
    chk("release_1", id_addr, 32'h14);
    tick();
    chk("release_2", id_addr, 32'h18);
    drive(1'b0, 32'h0); tick();

    // Flush in TWO with a pending (blocked) input: two drops.
    drive(1'b1, 32'h20); tick();
    id_stall = 1'b1; drive(1'b1, 32'h24); tick();
    drive(1'b1, 32'h28); flush = 1'b1; tick();
    chk("flush2_drops", {24'd0, flush_drops}, 32'd2);
    chk("flush2_valid", {31'd0, id_valid}, 32'd0);
    chk("flush2_inst", id_inst, 32'h0000_0013);
    chk("flush2_ready", {31'd0, if_ready}, 32'd1);
    flush = 1'b0; id_stall = 1'b0; drive(1'b0, 32'h0); tick();

    // Flush in ONE with consume and a concurrent transfer: one drop.
    drive(1'b1, 32'h30); tick();
    drive(1'b1, 32'h34); flush = 1'b1; tick();
    chk("flush1_drops", {24'd0, flush_drops}, 32'd3);
    flush = 1'b0; drive(1'b1, 32'h100); tick();
    chk("after_flush_addr", id_addr, 32'h100);
    chk("after_flush_valid", {31'd0, id_valid}, 32'd1);
    drive(1'b0, 32'h0); tick();
    chk("after_flush_alone", {31'd0, id_valid}, 32'd0);

    // Saturation: every flush cycle drops the concurrent transfer.
    flush = 1'b1; drive(1'b1, 32'h200);
    for (int i = 0; i < 300; i++) tick();
    chk("sat_ff", {24'd0, flush_drops}, 32'hFF);
    tick();
    chk("sat_hold", {24'd0, flush_drops}, 32'hFF);
    rst = 1'b0; tick();
    chk("sat_clear", {24'd0, flush_drops}, 32'd0);
    rst = 1'b1; flush = 1'b0; drive(1'b0, 32'h0); tick();

    @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
